// File: rtl/alu_packet_engine.sv
// Framed-packet engine: echoes payload bytes or folds operands (add/mul/xor) into one result, emitted LSB first.
// Echo: 1 cycle rx->tx. ALU: result byte0 two edges after the last operand byte. Both sides valid/ready; tx never retracts.
module alu_packet_engine #(
  parameter int OPERAND_WIDTH_P = 32,
  parameter int ERR_WIDTH_P     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  output logic                   rx_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic [ERR_WIDTH_P-1:0] err_count_o,
  output logic                   busy_o
);
  localparam int OPERAND_BYTES = OPERAND_WIDTH_P / 8;
  localparam int BCW = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(OPERAND_BYTES - 1);
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_XOR  = 8'hA2;

  typedef enum logic [2:0] {HDR, ECHO, OPERAND, COMPUTE, RESULT, DROP} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [1:0]                 hdr_cnt;
  logic [7:0]                 opcode;
  logic [7:0]                 len_lo;
  logic [15:0]                rem_cnt;
  logic [BCW-1:0]             byte_cnt;
  logic [OPERAND_WIDTH_P-1:0] opnd_sr;
  logic [OPERAND_WIDTH_P-1:0] acc;
  logic                       first_op;
  logic [OPERAND_WIDTH_P-1:0] out_sr;
  logic                       err_inc;

  logic                       rx_fire;
  logic                       tx_fire;
  logic [15:0]                len_w;
  logic [15:0]                payload;
  logic                       is_alu;
  logic [OPERAND_WIDTH_P-1:0] rx_ext;
  logic [OPERAND_WIDTH_P-1:0] opnd_nxt;
  logic [OPERAND_WIDTH_P-1:0] fold_res;
  logic [OPERAND_WIDTH_P-1:0] out_shift;

  function automatic logic [OPERAND_WIDTH_P-1:0] alu_fold(
    input logic [7:0]                 op,
    input logic [OPERAND_WIDTH_P-1:0] a,
    input logic [OPERAND_WIDTH_P-1:0] b
  );
    case (op)
      OP_ADD:  return a + b;
      OP_MUL:  return a * b;
      default: return a ^ b;
    endcase
  endfunction

  assign rx_fire   = rx_valid_i & rx_ready_o;
  assign tx_fire   = tx_valid_o & tx_ready_i;
  assign len_w     = {rx_data_i, len_lo};
  assign payload   = len_w - 16'd4;
  assign is_alu    = (opcode == OP_ADD) || (opcode == OP_MUL) || (opcode == OP_XOR);
  assign rx_ext    = OPERAND_WIDTH_P'(rx_data_i);
  // Little-endian assembly: new bytes enter at the top, so the first byte ends up as the LSB.
  assign opnd_nxt  = (opnd_sr >> 8) | (rx_ext << (OPERAND_WIDTH_P - 8));
  assign fold_res  = first_op ? opnd_sr : alu_fold(opcode, acc, opnd_sr);
  assign out_shift = out_sr >> 8;
  assign busy_o    = (state != HDR) || (hdr_cnt != 2'd0);

  always_comb begin
    rx_ready_o = 1'b0;
    case (state)
      HDR, OPERAND: rx_ready_o = 1'b1;
      ECHO:         rx_ready_o = (rem_cnt != 16'd0) && (!tx_valid_o || tx_ready_i);
      DROP:         rx_ready_o = (rem_cnt != 16'd0);
      default:      rx_ready_o = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    err_inc   = 1'b0;
    case (state)
      HDR: begin
        if (rx_fire && hdr_cnt == 2'd3) begin
          if (len_w < 16'd4) begin
            err_inc = 1'b1;
          end else if (opcode == OP_ECHO) begin
            if (payload != 16'd0) state_nxt = ECHO;
          end else if (!is_alu) begin
            state_nxt = DROP;
            err_inc   = 1'b1;
          end else if (payload == 16'd0 || (payload % 16'(OPERAND_BYTES)) != 16'd0) begin
            state_nxt = DROP;
            err_inc   = 1'b1;
          end else begin
            state_nxt = OPERAND;
          end
        end
      end
      ECHO: begin
        if (rem_cnt == 16'd0 && (!tx_valid_o || tx_ready_i)) state_nxt = HDR;
      end
      OPERAND: begin
        if (rx_fire && rem_cnt == 16'd1) state_nxt = COMPUTE;
      end
      COMPUTE: state_nxt = RESULT;
      RESULT: begin
        if (tx_fire && byte_cnt == LAST_BYTE) state_nxt = HDR;
      end
      DROP: begin
        if (rem_cnt == 16'd0 || (rx_fire && rem_cnt == 16'd1)) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= HDR;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_cnt     <= 2'd0;
      opcode      <= 8'h00;
      len_lo      <= 8'h00;
      rem_cnt     <= 16'd0;
      byte_cnt    <= '0;
      opnd_sr     <= '0;
      acc         <= '0;
      first_op    <= 1'b1;
      out_sr      <= '0;
      tx_valid_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      err_count_o <= '0;
    end else begin
      if (err_inc && err_count_o != {ERR_WIDTH_P{1'b1}})
        err_count_o <= err_count_o + ERR_WIDTH_P'(1);
      case (state)
        HDR: begin
          if (rx_fire) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd0) opcode <= rx_data_i;
            if (hdr_cnt == 2'd2) len_lo <= rx_data_i;
            if (hdr_cnt == 2'd3) begin
              rem_cnt  <= payload;
              byte_cnt <= '0;
              first_op <= 1'b1;
            end
          end
        end
        ECHO: begin
          if (rx_fire) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= rx_data_i;
            rem_cnt    <= rem_cnt - 16'd1;
          end else if (tx_fire) begin
            tx_valid_o <= 1'b0;
          end
        end
        OPERAND: begin
          if (rx_fire) begin
            opnd_sr <= opnd_nxt;
            rem_cnt <= rem_cnt - 16'd1;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              // The final operand is left in opnd_sr and folded during COMPUTE.
              if (rem_cnt != 16'd1) begin
                acc      <= first_op ? opnd_nxt : alu_fold(opcode, acc, opnd_nxt);
                first_op <= 1'b0;
              end
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        COMPUTE: begin
          acc        <= fold_res;
          out_sr     <= fold_res;
          tx_valid_o <= 1'b1;
          tx_data_o  <= fold_res[7:0];
          byte_cnt   <= '0;
        end
        RESULT: begin
          if (tx_fire) begin
            if (byte_cnt == LAST_BYTE) begin
              tx_valid_o <= 1'b0;
            end else begin
              out_sr    <= out_shift;
              tx_data_o <= out_shift[7:0];
              byte_cnt  <= byte_cnt + BCW'(1);
            end
          end
        end
        DROP: begin
          if (rx_fire) rem_cnt <= rem_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Bench for alu_packet_engine: directed packets plus random packets checked against a byte-level packet model.
module tb_alu_packet_engine;
  localparam int W  = 32;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [EW-1:0] err_count;
  logic          busy;

  always #5 clk = ~clk;

  alu_packet_engine #(.OPERAND_WIDTH_P(W), .ERR_WIDTH_P(EW)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .err_count_o(err_count), .busy_o(busy)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         tx_mode  = 0;   // 0: always ready, 1: toggle, 2: random, 3: held by caller
  bit         rx_fire_s, busy_s, tv_s;
  bit         stall_prev = 1'b0;
  logic [7:0] hold_dat;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pk[$];
  int         rx_cyc[$];
  int         tx_cyc[$];
  int         exp_err;
  bit         watch_rdy = 1'b0;
  int         rdy_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_q(input string tag, input logic [7:0] e[$]);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk({tag, "_byte"}, (i < got_q.size()) ? {56'd0, got_q[i]} : 64'hdead, {56'd0, e[i]});
  endtask

  task automatic clear();
    got_q.delete(); rx_cyc.delete(); tx_cyc.delete();
  endtask

  // One clock: drive tx_ready, sample everything at the falling edge, resume 1 ns after the rising edge.
  task automatic tick();
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    @(negedge clk);
    if (stall_prev) begin
      chk("tx_hold_vld", {63'd0, tx_valid}, 64'd1);
      chk("tx_hold_dat", {56'd0, tx_data}, {56'd0, hold_dat});
    end
    rx_fire_s = rx_valid && rx_ready;
    if (rx_fire_s) rx_cyc.push_back(cyc);
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    if (watch_rdy && tx_valid && rx_ready) rdy_bad++;
    busy_s     = busy;
    tv_s       = tx_valid;
    stall_prev = tx_valid && !tx_ready && !rst;
    hold_dat   = tx_data;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p[$], input bit gaps);
    int idx = 0;
    int n   = 0;
    while (idx < p.size() && n < 5000) begin
      rx_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rx_data  = p[idx];
      tick();
      if (rx_fire_s) idx++;
      n++;
    end
    rx_valid = 1'b0;
    chk("send_timeout", 64'(n < 5000), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      tick();
      n++;
    end while ((busy_s || tv_s) && n < 3000);
    chk("drain_timeout", 64'(n < 3000), 64'd1);
  endtask

  task automatic do_reset();
    tx_mode  = 3;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
  endtask

  task automatic bump_err();
    exp_err = (exp_err < 3) ? exp_err + 1 : 3;
  endtask

  // Reference: whole-packet semantics with plain integer arithmetic on 32-bit words.
  task automatic model_pkt(input logic [7:0] p[$]);
    int                len, pay;
    longint unsigned   acc, w, bv;
    len = int'(p[2]) + 256 * int'(p[3]);
    pay = len - 4;
    if (len < 4) bump_err();
    else if (p[0] == 8'hEC) begin
      for (int i = 0; i < pay; i++) exp_q.push_back(p[4+i]);
    end else if (p[0] < 8'hA0 || p[0] > 8'hA2) bump_err();
    else if (pay == 0 || pay % 4 != 0) bump_err();
    else begin
      acc = 0;
      for (int k = 0; k < pay / 4; k++) begin
        w = 0;
        for (int b = 0; b < 4; b++) begin
          bv = p[4 + 4*k + b];
          w  = w + (bv << (8*b));
        end
        if (k == 0)              acc = w;
        else if (p[0] == 8'hA0)  acc = (acc + w) & 64'hFFFF_FFFF;
        else if (p[0] == 8'hA1)  acc = (acc * w) & 64'hFFFF_FFFF;
        else                     acc = acc ^ w;
      end
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8*b)));
    end
  endtask

  task automatic gen_pkt(output logic [7:0] p[$]);
    int         kind, pay, len;
    logic [7:0] op;
    kind = $urandom_range(0, 5);
    pay  = 0;
    op   = 8'hEC;
    case (kind)
      0: begin op = 8'hEC; pay = $urandom_range(0, 8); end
      1, 2: begin op = 8'hA0 + 8'($urandom_range(0, 2)); pay = 4 * $urandom_range(1, 3); end
      3: begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'hEC || (op >= 8'hA0 && op <= 8'hA2)) op = 8'h55;
        pay = $urandom_range(0, 6);
      end
      4: begin
        op  = 8'hA0 + 8'($urandom_range(0, 2));
        pay = $urandom_range(0, 6);
        if (pay >= 4) pay++;
      end
      default: op = 8'($urandom_range(0, 255));
    endcase
    len = (kind == 5) ? $urandom_range(0, 3) : pay + 4;
    p.delete();
    p.push_back(op);
    p.push_back(8'($urandom_range(0, 255)));
    p.push_back(8'(len));
    p.push_back(8'(len >> 8));
    if (kind != 5)
      for (int i = 0; i < pay; i++) p.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_data",  {56'd0, tx_data},  64'h00);
    chk("rst_err",      64'(err_count),    64'd0);
    chk("rst_busy",     {63'd0, busy},     64'd0);

    // Echo, back-to-back
    tx_mode = 0; clear();
    pk = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send(pk, 1'b0); drain();
    chk_q("echo", '{8'h41, 8'h42, 8'h43});
    for (int i = 0; i < 3; i++)
      chk("echo_latency", (i < tx_cyc.size() && 4 + i < rx_cyc.size()) ? 64'(tx_cyc[i] - rx_cyc[4+i]) : 64'hdead, 64'd1);
    chk("echo_err", 64'(err_count), 64'd0);

    // Add with wrap, latency from last operand byte
    clear();
    pk = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send(pk, 1'b0); drain();
    chk_q("add", '{8'h01, 8'h00, 8'h00, 8'h00});
    chk("add_latency", (tx_cyc.size() > 0 && rx_cyc.size() == 12) ? 64'(tx_cyc[0] - rx_cyc[11]) : 64'hdead, 64'd2);

    // Multiply under toggling backpressure
    clear(); tx_mode = 1; watch_rdy = 1'b1; rdy_bad = 0;
    pk = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send(pk, 1'b0); drain();
    watch_rdy = 1'b0;
    chk_q("mul", '{8'h0F, 8'h00, 8'h00, 8'h00});
    chk("mul_rx_ready_in_result", 64'(rdy_bad), 64'd0);

    // Malformed packets then a single-operand xor
    do_reset(); tx_mode = 0; clear();
    pk = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};              send(pk, 1'b0);
    pk = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};       send(pk, 1'b0);
    pk = '{8'hA2, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}; send(pk, 1'b0);
    drain();
    chk("malformed_err", 64'(err_count), 64'd2);
    chk_q("malformed", '{8'h78, 8'h56, 8'h34, 8'h12});

    // Saturation with short LEN; each consumes only its 4 header bytes
    do_reset(); tx_mode = 0; clear();
    for (int i = 0; i < 5; i++) begin
      pk = '{8'hEC, 8'h00, 8'h02, 8'h00};
      send(pk, 1'b0);
    end
    drain();
    chk("sat_err", 64'(err_count), 64'd3);
    pk = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send(pk, 1'b0); drain();
    chk_q("sat_echo", '{8'h5A});
    chk("sat_err_hold", 64'(err_count), 64'd3);

    // Reset mid-RESULT after one byte
    do_reset(); clear();
    pk = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h00, 8'h00, 8'h00};
    send(pk, 1'b0);
    begin
      int n = 0;
      while (!tx_valid && n < 100) begin tick(); n++; end
      chk("mid_wait_tx", 64'(n < 100), 64'd1);
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    chk_q("mid_first", '{8'h12});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("mid_err", 64'(err_count), 64'd0);
    chk("mid_busy", {63'd0, busy}, 64'd0);
    tx_mode = 0;
    pk = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hC3, 8'h3C};
    send(pk, 1'b0); drain();
    chk_q("mid_echo", '{8'h12, 8'hC3, 8'h3C});

    // Random packets, random rx gaps and tx backpressure
    do_reset(); clear(); exp_q.delete(); exp_err = 0; tx_mode = 2;
    for (int i = 0; i < 40; i++) begin
      gen_pkt(pk);
      model_pkt(pk);
      send(pk, 1'b1);
    end
    drain();
    chk_q("random", exp_q);
    chk("random_err", 64'(err_count), 64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
